buzzer_arbiter: RTL

Shares the single board buzzer between three requesters: the matrix keypad (hold-to-sound note), the CPU (timed note jobs) and a system alarm (repeating beep pattern). Resolves priority alarm > CPU > keypad and generates the square-wave tone for the winning requester from an 8-entry note table. Sits between the keypad scanner / CPU IO register file and the `buzzer_out` board pin.

---
 rtl/buzzer_arbiter_if.sv | 24 ++
 rtl/buzzer_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/buzzer_arbiter_if.sv
// Request/response bundle between the keypad scanner, the CPU IO registers and the buzzer arbiter.
// The requester side drives the requests; the arbiter drives the tone pin and the status flags.
interface buzzer_arbiter_if;
  logic        key_req;
  logic [2:0]  key_note;
  logic        cpu_start;
  logic [2:0]  cpu_note;
  logic [15:0] cpu_dur_ms;
  logic        alarm_req;
  logic        buzzer_out;
  logic [1:0]  owner;
  logic        cpu_busy;
  logic        cpu_done;

  modport master (
    output key_req, key_note, cpu_start, cpu_note, cpu_dur_ms, alarm_req,
    input  buzzer_out, owner, cpu_busy, cpu_done
  );

  modport slave (
    input  key_req, key_note, cpu_start, cpu_note, cpu_dur_ms, alarm_req,
    output buzzer_out, owner, cpu_busy, cpu_done
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// Shares the board buzzer between alarm, CPU note jobs and keypad (in that priority order)
// and generates the square-wave tone of the winning requester from an 8-entry note table.
module buzzer_arbiter #(
  parameter int TICK_DIV     = 100000,
  parameter int NOTE_SHIFT   = 0,
  parameter int ALARM_ON_MS  = 200,
  parameter int ALARM_OFF_MS = 300
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  buzzer_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_CPU, S_ALARM_ON, S_ALARM_OFF
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]   ON_LAST    = 16'(ALARM_ON_MS - 1);
  localparam logic [15:0]   OFF_LAST   = 16'(ALARM_OFF_MS - 1);
  localparam logic [17:0]   HP_BASE [8] = '{
    18'd190840, 18'd170068, 18'd151515, 18'd143266,
    18'd127551, 18'd113636, 18'd101214, 18'd95602
  };

  logic [17:0] hp_table [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hp
      assign hp_table[gi] = HP_BASE[gi] >> NOTE_SHIFT;
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [17:0]   hp_cnt_reg, hp_cnt_next;
  logic          buzzer_reg, buzzer_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [15:0]   dur_left_reg, dur_left_next;
  logic [15:0]   phase_reg, phase_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [2:0]    cpu_note_reg, cpu_note_next;
  logic [2:0]    note_reg, note_next;
  logic [1:0]    owner_w;

  logic        tick, accept, zero_job, finish;
  logic        entering, in_alarm_next, tone_next;
  logic [17:0] hp_cur;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= S_IDLE;
      hp_cnt_reg   <= '0;
      buzzer_reg   <= 1'b0;
      presc_reg    <= '0;
      dur_left_reg <= '0;
      phase_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      cpu_note_reg <= '0;
      note_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      hp_cnt_reg   <= hp_cnt_next;
      buzzer_reg   <= buzzer_next;
      presc_reg    <= presc_next;
      dur_left_reg <= dur_left_next;
      phase_reg    <= phase_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      cpu_note_reg <= cpu_note_next;
      note_reg     <= note_next;
    end
  end

  always_comb begin
    tick     = (presc_reg == PRESC_LAST);
    accept   = bus.cpu_start && !busy_reg && (bus.cpu_dur_ms != 16'd0);
    zero_job = bus.cpu_start && !busy_reg && (bus.cpu_dur_ms == 16'd0);
    // The job only ages while it owns the buzzer; a preempted job keeps its remaining ticks.
    finish   = (state_reg == S_CPU) && tick && (dur_left_reg == 16'd1);

    dur_left_next = dur_left_reg;
    if (accept) begin
      dur_left_next = bus.cpu_dur_ms;
    end else if ((state_reg == S_CPU) && tick) begin
      dur_left_next = dur_left_reg - 16'd1;
    end
    busy_next     = accept || (busy_reg && !finish);
    done_next     = finish || zero_job;
    cpu_note_next = accept ? bus.cpu_note : cpu_note_reg;

    state_next = S_IDLE;
    if (bus.alarm_req) begin
      case (state_reg)
        S_ALARM_ON:  state_next = (tick && (phase_reg == ON_LAST))  ? S_ALARM_OFF : S_ALARM_ON;
        S_ALARM_OFF: state_next = (tick && (phase_reg == OFF_LAST)) ? S_ALARM_ON  : S_ALARM_OFF;
        default:     state_next = S_ALARM_ON;
      endcase
    end else if (busy_next) begin
      state_next = S_CPU;
    end else if (bus.key_req) begin
      state_next = S_KEY;
    end

    entering      = (state_next != state_reg);
    in_alarm_next = (state_next == S_ALARM_ON) || (state_next == S_ALARM_OFF);

    phase_next = 16'd0;
    if (in_alarm_next && !entering) begin
      phase_next = tick ? (phase_reg + 16'd1) : phase_reg;
    end

    // Restarting the prescaler on resume makes a preemption cost at most one partial tick.
    presc_next = tick ? '0 : (presc_reg + PW'(1));
    if (accept || (entering && ((state_next == S_CPU) || in_alarm_next))) begin
      presc_next = '0;
    end

    note_next = note_reg;
    case (state_next)
      S_KEY:      note_next = bus.key_note;
      S_CPU:      note_next = cpu_note_next;
      S_ALARM_ON: note_next = 3'd7;
      default:    ;
    endcase

    tone_next   = (state_next == S_KEY) || (state_next == S_CPU) || (state_next == S_ALARM_ON);
    hp_cur      = hp_table[note_reg];
    hp_cnt_next = hp_cnt_reg + 18'd1;
    buzzer_next = buzzer_reg;
    if (!tone_next) begin
      hp_cnt_next = '0;
      buzzer_next = 1'b0;
    end else if (entering || (note_next != note_reg)) begin
      hp_cnt_next = '0;
      buzzer_next = 1'b1;
    end else if (hp_cnt_reg == (hp_cur - 18'd1)) begin
      hp_cnt_next = '0;
      buzzer_next = ~buzzer_reg;
    end
  end

  always_comb begin
    case (state_reg)
      S_KEY:       owner_w = 2'd1;
      S_CPU:       owner_w = 2'd2;
      S_ALARM_ON:  owner_w = 2'd3;
      S_ALARM_OFF: owner_w = 2'd3;
      default:     owner_w = 2'd0;
    endcase
  end

  assign bus.buzzer_out = buzzer_reg;
  assign bus.owner      = owner_w;
  assign bus.cpu_busy   = busy_reg;
  assign bus.cpu_done   = done_reg;

endmodule
